// File: rtl/fp_addsub_pipe_if.sv
// Operand/result handshake bundle for fp_addsub_pipe: valid/ready on both sides.
interface fp_addsub_pipe_if #(
   parameter int unsigned EXP_W = 5,
   parameter int unsigned MAN_W = 10
);
   localparam int unsigned W = 1 + EXP_W + MAN_W;

   logic         in_valid;
   logic         in_ready;
   logic [W-1:0] a;
   logic [W-1:0] b;
   logic         op;
   logic         out_valid;
   logic         out_ready;
   logic [W-1:0] result;
   logic [3:0]   flags;

   modport master (
      output in_valid, a, b, op, out_ready,
      input  in_ready, out_valid, result, flags
   );

   modport slave (
      input  in_valid, a, b, op, out_ready,
      output in_ready, out_valid, result, flags
   );
endinterface

// File: rtl/fp_addsub_pipe.sv
// Three-stage floating-point adder/subtractor, round-to-nearest-even, flush-to-zero.
// Stages: unpack/swap/align -> magnitude add/sub -> normalise/round/pack.
module fp_addsub_pipe #(
   parameter int unsigned EXP_W = 5,
   parameter int unsigned MAN_W = 10
) (
   input  logic            CLK,
   input  logic            RESETn,
   fp_addsub_pipe_if.slave bus
);
   localparam int unsigned W    = 1 + EXP_W + MAN_W;
   localparam int unsigned XW   = MAN_W + 4;
   localparam int unsigned SHW  = $clog2(XW + 1);
   localparam int unsigned EW   = ((EXP_W > SHW) ? EXP_W : SHW) + 2;
   localparam int unsigned EMAX = (1 << EXP_W) - 1;

   typedef struct packed {
      logic             valid;
      logic             special;
      logic [W-1:0]     spec_res;
      logic [3:0]       spec_flg;
      logic             sign;
      logic [EXP_W-1:0] exp;
      logic             eff_sub;
      logic [XW-1:0]    x;
      logic [XW-1:0]    y;
   } s1_t;

   typedef struct packed {
      logic             valid;
      logic             special;
      logic [W-1:0]     spec_res;
      logic [3:0]       spec_flg;
      logic             sign;
      logic [EXP_W-1:0] exp;
      logic [XW:0]      sum;
   } s2_t;

   s1_t          s1_q, s1_d;
   s2_t          s2_q, s2_d;
   logic         out_valid_q;
   logic [W-1:0] result_q;
   logic [3:0]   flags_q;
   logic         advance_c;

   assign advance_c     = ~out_valid_q | bus.out_ready;
   assign bus.in_ready  = advance_c;
   assign bus.out_valid = out_valid_q;
   assign bus.result    = result_q;
   assign bus.flags     = flags_q;

   logic             sa, sb;
   logic [EXP_W-1:0] ea, eb;
   logic [MAN_W-1:0] ma, mb;
   logic             nan_a, nan_b, inf_a, inf_b, zero_a, zero_b, a_big;
   logic [W-1:0]     bf_c;
   logic [EXP_W-1:0] d_c;
   logic [SHW-1:0]   sh_c;
   logic [2*XW-1:0]  ysh_c;

   // Stage 1: classify, pick the larger magnitude as X, align Y with sticky collapse.
   always_comb begin
      bf_c   = {bus.b[W-1] ^ bus.op, bus.b[W-2:0]};
      {sa, ea, ma} = bus.a;
      {sb, eb, mb} = bf_c;
      nan_a  = (ea == '1) && (ma != '0);
      nan_b  = (eb == '1) && (mb != '0);
      inf_a  = (ea == '1) && (ma == '0);
      inf_b  = (eb == '1) && (mb == '0);
      zero_a = (ea == '0);
      zero_b = (eb == '0);
      a_big  = {ea, ma} >= {eb, mb};

      s1_d         = '0;
      s1_d.valid   = bus.in_valid;
      s1_d.special = 1'b1;
      if (nan_a || nan_b || (inf_a && inf_b && (sa != sb))) begin
         s1_d.spec_res = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};
         s1_d.spec_flg = 4'b1000;
      end else if (inf_a) begin
         s1_d.spec_res = bus.a;
      end else if (inf_b) begin
         s1_d.spec_res = bf_c;
      end else if (zero_a && zero_b) begin
         s1_d.spec_res = {sa & sb, (W-1)'(0)};
      end else if (zero_a) begin
         s1_d.spec_res = bf_c;
      end else if (zero_b) begin
         s1_d.spec_res = bus.a;
      end else begin
         s1_d.special = 1'b0;
      end

      s1_d.eff_sub = sa ^ sb;
      s1_d.sign    = a_big ? sa : sb;
      s1_d.exp     = a_big ? ea : eb;
      d_c          = a_big ? (ea - eb) : (eb - ea);
      sh_c         = (32'(d_c) >= XW) ? SHW'(XW) : SHW'(d_c);
      ysh_c        = {1'b1, (a_big ? mb : ma), 3'b000, {XW{1'b0}}} >> sh_c;
      s1_d.x       = {1'b1, (a_big ? ma : mb), 3'b000};
      s1_d.y       = {ysh_c[2*XW-1:XW+1], ysh_c[XW] | (|ysh_c[XW-1:0])};
   end

   // Stage 2: magnitude add or subtract; X >= aligned Y so the difference never wraps.
   always_comb begin
      s2_d          = '0;
      s2_d.valid    = s1_q.valid;
      s2_d.special  = s1_q.special;
      s2_d.spec_res = s1_q.spec_res;
      s2_d.spec_flg = s1_q.spec_flg;
      s2_d.sign     = s1_q.sign;
      s2_d.exp      = s1_q.exp;
      s2_d.sum      = s1_q.eff_sub ? ({1'b0, s1_q.x} - {1'b0, s1_q.y})
                                   : ({1'b0, s1_q.x} + {1'b0, s1_q.y});
   end

   logic [SHW-1:0]   lz_c;
   logic [XW-1:0]    norm_c;
   logic [EW-1:0]    e_c, e2_c;
   logic [MAN_W+1:0] rnd_c;
   logic [MAN_W-1:0] mant_c;
   logic             rup_c, inexact_c;
   logic [W-1:0]     res_c;
   logic [3:0]       flg_c;

   // Stage 3: normalise, round to nearest even, detect range limits, select specials.
   always_comb begin
      lz_c = SHW'(XW);
      for (int i = 0; i < XW; i++) begin
         if (s2_q.sum[i]) lz_c = SHW'(XW - 1 - i);
      end
      if (s2_q.sum[XW]) begin
         norm_c = {s2_q.sum[XW:2], s2_q.sum[1] | s2_q.sum[0]};
         e_c    = EW'(s2_q.exp) + EW'(1);
      end else begin
         norm_c = s2_q.sum[XW-1:0] << lz_c;
         e_c    = EW'(s2_q.exp) - EW'(lz_c);
      end
      rup_c     = norm_c[2] & (norm_c[1] | norm_c[0] | norm_c[3]);
      inexact_c = |norm_c[2:0];
      rnd_c     = {1'b0, norm_c[XW-1:3]} + (MAN_W+2)'(rup_c);
      mant_c    = rnd_c[MAN_W+1] ? rnd_c[MAN_W:1] : rnd_c[MAN_W-1:0];
      e2_c      = e_c + EW'(rnd_c[MAN_W+1]);

      res_c = '0;
      flg_c = '0;
      if (s2_q.special) begin
         res_c = s2_q.spec_res;
         flg_c = s2_q.spec_flg;
      end else if (s2_q.sum == '0) begin
         res_c = '0;
      end else if ($signed(e2_c) <= 0) begin
         res_c = {s2_q.sign, (W-1)'(0)};
         flg_c = 4'b0011;
      end else if ($signed(e2_c) >= $signed(EW'(EMAX))) begin
         res_c = {s2_q.sign, {EXP_W{1'b1}}, MAN_W'(0)};
         flg_c = 4'b0101;
      end else begin
         res_c = {s2_q.sign, e2_c[EXP_W-1:0], mant_c};
         flg_c = {3'b000, inexact_c};
      end
   end

   // All stages shift together; a stalled output freezes the whole pipe.
   always_ff @(posedge CLK or negedge RESETn) begin
      if (!RESETn) begin
         s1_q        <= '0;
         s2_q        <= '0;
         out_valid_q <= 1'b0;
         result_q    <= '0;
         flags_q     <= '0;
      end else if (advance_c) begin
         s1_q        <= s1_d;
         s2_q        <= s2_d;
         out_valid_q <= s2_q.valid;
         if (s2_q.valid) begin
            result_q <= res_c;
            flags_q  <= flg_c;
         end
      end
   end
endmodule

// File: tb/tb_fp_addsub_pipe.sv
// Scoreboard bench for fp_addsub_pipe: directed corner cases plus random traffic
// checked against an exact integer model of binary16 add/sub with RNE and FTZ.
module tb_fp_addsub_pipe;
   localparam int MW   = 10;
   localparam int XEW  = 5;
   localparam int EALL = 31;

   typedef struct packed {
      logic [15:0] res;
      logic [3:0]  flg;
      logic [15:0] a;
      logic [15:0] b;
      logic        op;
   } exp_t;

   logic clk;
   logic rst_n;
   int   checks = 0;
   int   errors = 0;
   int   n_in   = 0;
   int   n_out  = 0;
   bit   rand_rdy = 0;
   exp_t exp_q[$];

   fp_addsub_pipe_if bus ();

   fp_addsub_pipe dut (
      .CLK    (clk),
      .RESETn (rst_n),
      .bus    (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic longint to_units(input logic [15:0] x);
      int     e;
      longint m;
      e = int'(x[14:10]);
      m = longint'(x[9:0]);
      if (e == 0) return 0;
      return ((longint'(1) << MW) + m) << (e - 1);
   endfunction

   // Exact sum in units of 2^-24, then rounded to an 11-bit significand.
   function automatic exp_t model(input logic [15:0] a, input logic [15:0] b, input logic op);
      exp_t        r;
      logic        sa, sb, sign;
      logic [15:0] bf;
      int          ea, eb, p, sh, be;
      longint      s, mag, q, rem, half;
      bit          nan_a, nan_b, inf_a, inf_b, nx;
      r = '0; r.a = a; r.b = b; r.op = op;
      bf = {b[15] ^ op, b[14:0]};
      sa = a[15]; sb = bf[15];
      ea = int'(a[14:10]); eb = int'(bf[14:10]);
      nan_a = (ea == EALL) && (a[9:0] != 0);
      nan_b = (eb == EALL) && (bf[9:0] != 0);
      inf_a = (ea == EALL) && (a[9:0] == 0);
      inf_b = (eb == EALL) && (bf[9:0] == 0);
      if (nan_a || nan_b || (inf_a && inf_b && sa != sb)) begin r.res = 16'h7E00; r.flg = 4'b1000; return r; end
      if (inf_a) begin r.res = a; return r; end
      if (inf_b) begin r.res = bf; return r; end
      if (ea == 0 && eb == 0) begin r.res = {sa & sb, 15'h0}; return r; end
      if (ea == 0) begin r.res = bf; return r; end
      if (eb == 0) begin r.res = a; return r; end
      s = (sa ? -to_units(a) : to_units(a)) + (sb ? -to_units(bf) : to_units(bf));
      if (s == 0) begin r.res = 16'h0000; return r; end
      sign = (s < 0);
      mag  = sign ? -s : s;
      p = 0;
      for (int i = 0; i < 63; i++) if (mag[i]) p = i;
      if (p < MW) begin r.res = {sign, 15'h0}; r.flg = 4'b0011; return r; end
      sh   = p - MW;
      q    = mag >> sh;
      rem  = mag - (q << sh);
      half = (sh > 0) ? (longint'(1) << (sh - 1)) : 0;
      nx   = (rem != 0);
      if (sh > 0 && (rem > half || (rem == half && q[0]))) q = q + 1;
      be = sh + 1;
      if (q == (longint'(2) << MW)) begin q = longint'(1) << MW; be = be + 1; end
      if (be >= EALL) begin r.res = {sign, 5'h1F, 10'h0}; r.flg = 4'b0101; return r; end
      r.res = {sign, 5'(be), q[9:0]};
      r.flg = {3'b000, nx};
      return r;
   endfunction

   function automatic logic [15:0] rand_operand(input logic [15:0] other);
      logic [15:0] sp [6];
      logic [4:0]  e;
      sp[0] = 16'h0000; sp[1] = 16'h8000; sp[2] = 16'h7C00;
      sp[3] = 16'hFC00; sp[4] = 16'h7E00; sp[5] = 16'h7C01;
      case ($urandom_range(0, 9))
         0:       return sp[$urandom_range(0, 5)];
         1, 2, 3: begin
            e = other[14:10] ^ 5'($urandom_range(0, 3));
            return {1'($urandom), e, 10'($urandom)};
         end
         4:       return {1'($urandom), other[14:0] ^ 15'($urandom_range(0, 3))};
         default: return 16'($urandom);
      endcase
   endfunction

   // Output side: compare every presented result with the scoreboard head.
   always @(negedge clk) begin
      if (rst_n && bus.out_valid) begin
         checks++;
         if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_output got=%h flags=%b want=nothing", bus.result, bus.flags);
         end else begin
            if (bus.result !== exp_q[0].res || bus.flags !== exp_q[0].flg) begin
               errors++;
               $display("FAIL result a=%h b=%h op=%0d got=%h flags=%b want=%h flags=%b",
                        exp_q[0].a, exp_q[0].b, exp_q[0].op, bus.result, bus.flags, exp_q[0].res, exp_q[0].flg);
            end
            if (bus.out_ready) begin
               void'(exp_q.pop_front());
               n_out++;
            end
         end
      end
   end

   task automatic push_exp(input exp_t e);
      exp_q.push_back(e);
      n_in++;
   endtask

   // Called just after a rising edge; holds the operands until accepted.
   task automatic send(input logic [15:0] a, input logic [15:0] b, input logic op,
                       input bit use_model, input logic [15:0] res, input logic [3:0] flg);
      exp_t e;
      bit   done = 0;
      if (use_model) e = model(a, b, op);
      else begin e.res = res; e.flg = flg; e.a = a; e.b = b; e.op = op; end
      bus.a = a; bus.b = b; bus.op = op; bus.in_valid = 1'b1;
      for (int t = 0; t < 64 && !done; t++) begin
         @(negedge clk);
         if (bus.in_ready) begin push_exp(e); done = 1; end
         @(posedge clk); #1;
         if (rand_rdy) bus.out_ready = ($urandom_range(0, 9) < 7);
      end
      bus.in_valid = 1'b0;
      if (!done) begin
         checks++; errors++;
         $display("FAIL accept_timeout a=%h b=%h got=not_accepted want=accepted", a, b);
      end
   endtask

   task automatic drain();
      int t = 0;
      bus.out_ready = 1'b1;
      while (exp_q.size() != 0 && t < 200) begin @(posedge clk); #1; t++; end
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL drain_timeout pending=%0d want=0", exp_q.size());
      end
   endtask

   task automatic check_latency(input logic [15:0] a, input logic [15:0] b, input logic op,
                                input logic [15:0] res, input logic [3:0] flg);
      exp_t e;
      int   lat = 0;
      e.res = res; e.flg = flg; e.a = a; e.b = b; e.op = op;
      bus.a = a; bus.b = b; bus.op = op; bus.in_valid = 1'b1;
      @(negedge clk);
      checks++;
      if (!bus.in_ready) begin errors++; $display("FAIL idle_in_ready got=0 want=1"); end
      push_exp(e);
      @(posedge clk); #1;
      bus.in_valid = 1'b0;
      for (int t = 1; t <= 8 && lat == 0; t++) begin
         @(negedge clk);
         if (bus.out_valid) lat = t;
      end
      checks++;
      if (lat != 3) begin errors++; $display("FAIL latency got=%0d want=3", lat); end
      @(posedge clk); #1;
   endtask

   logic [15:0] da [11];
   logic [15:0] db [11];
   logic        dop[11];
   logic [15:0] dres[11];
   logic [3:0]  dflg[11];

   initial begin
      int base_in, base_out;
      rst_n = 1'b0;
      bus.in_valid = 1'b0; bus.a = '0; bus.b = '0; bus.op = 1'b0; bus.out_ready = 1'b1;
      #2;
      checks += 3;
      if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got=%b want=0", bus.out_valid); end
      if (bus.result !== 16'h0)   begin errors++; $display("FAIL reset_result got=%h want=0000", bus.result); end
      if (bus.flags !== 4'h0)     begin errors++; $display("FAIL reset_flags got=%b want=0000", bus.flags); end
      #20 rst_n = 1'b1;
      @(posedge clk); #1;
      checks++;
      if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got=%b want=1", bus.in_ready); end

      check_latency(16'h3C00, 16'h3C00, 1'b0, 16'h4000, 4'b0000);

      da[0] = 16'h3C00; db[0] = 16'h3C00; dop[0] = 1; dres[0] = 16'h0000; dflg[0] = 4'b0000;
      da[1] = 16'hBC00; db[1] = 16'h3C00; dop[1] = 0; dres[1] = 16'h0000; dflg[1] = 4'b0000;
      da[2] = 16'h3C00; db[2] = 16'h1000; dop[2] = 0; dres[2] = 16'h3C00; dflg[2] = 4'b0001;
      da[3] = 16'h3C01; db[3] = 16'h1000; dop[3] = 0; dres[3] = 16'h3C02; dflg[3] = 4'b0001;
      da[4] = 16'h7BFF; db[4] = 16'h7BFF; dop[4] = 0; dres[4] = 16'h7C00; dflg[4] = 4'b0101;
      da[5] = 16'h7C00; db[5] = 16'h7C00; dop[5] = 1; dres[5] = 16'h7E00; dflg[5] = 4'b1000;
      da[6] = 16'h7C01; db[6] = 16'h3C00; dop[6] = 0; dres[6] = 16'h7E00; dflg[6] = 4'b1000;
      da[7] = 16'h8000; db[7] = 16'h8000; dop[7] = 0; dres[7] = 16'h8000; dflg[7] = 4'b0000;
      da[8] = 16'h0000; db[8] = 16'h8000; dop[8] = 0; dres[8] = 16'h0000; dflg[8] = 4'b0000;
      da[9] = 16'h0401; db[9] = 16'h0400; dop[9] = 1; dres[9] = 16'h0000; dflg[9] = 4'b0011;
      da[10] = 16'h0400; db[10] = 16'h0401; dop[10] = 1; dres[10] = 16'h8000; dflg[10] = 4'b0011;
      for (int i = 0; i < 11; i++) send(da[i], db[i], dop[i], 0, dres[i], dflg[i]);
      drain();

      // Back-to-back with the consumer stalled: only three ops fit in the pipe.
      bus.out_ready = 1'b0;
      base_in = n_in;
      fork
         begin
            send(16'h3C00, 16'h4000, 1'b0, 1, '0, '0);
            send(16'h4200, 16'h3C00, 1'b1, 1, '0, '0);
            send(16'h5640, 16'hC900, 1'b0, 1, '0, '0);
            send(16'h3555, 16'h2AAA, 1'b1, 1, '0, '0);
         end
         begin
            repeat (6) @(negedge clk);
            checks += 2;
            if (n_in - base_in != 3) begin errors++; $display("FAIL stall_accepted got=%0d want=3", n_in - base_in); end
            if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL stall_in_ready got=%b want=0", bus.in_ready); end
            @(posedge clk); #1;
            bus.out_ready = 1'b1;
            base_out = n_out;
            repeat (4) @(negedge clk);
            #1;
            checks++;
            if (n_out - base_out != 4) begin errors++; $display("FAIL release_rate got=%0d want=4", n_out - base_out); end
         end
      join
      drain();

      // Reset with three ops in flight; they must vanish.
      @(posedge clk); #1;
      bus.out_ready = 1'b0;
      send(16'h3C00, 16'h3C00, 1'b0, 1, '0, '0);
      send(16'h4000, 16'h3C00, 1'b0, 1, '0, '0);
      send(16'h4400, 16'h3C00, 1'b1, 1, '0, '0);
      #1;
      exp_q.delete();
      rst_n = 1'b0;
      #1;
      checks += 3;
      if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL midreset_out_valid got=%b want=0", bus.out_valid); end
      if (bus.result !== 16'h0)   begin errors++; $display("FAIL midreset_result got=%h want=0000", bus.result); end
      if (bus.flags !== 4'h0)     begin errors++; $display("FAIL midreset_flags got=%b want=0000", bus.flags); end
      repeat (2) @(negedge clk);
      checks++;
      if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL inreset_out_valid got=%b want=0", bus.out_valid); end
      @(posedge clk); #3;
      rst_n = 1'b1;
      bus.out_ready = 1'b1;
      @(posedge clk); #1;
      check_latency(16'h4000, 16'h4000, 1'b0, 16'h4400, 4'b0000);
      drain();

      // Random traffic with a randomly stalling consumer.
      rand_rdy = 1;
      for (int i = 0; i < 400; i++) begin
         logic [15:0] ra, rb;
         ra = 16'($urandom);
         if ($urandom_range(0, 3) == 0) ra = rand_operand(16'h3C00);
         rb = rand_operand(ra);
         send(ra, rb, 1'($urandom), 1, '0, '0);
         if ($urandom_range(0, 7) == 0) begin
            @(posedge clk); #1;
            bus.out_ready = ($urandom_range(0, 9) < 7);
         end
      end
      rand_rdy = 0;
      drain();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
